param_entry_ctrl: RTL and testbench

// Sequences keyboard entry of alarm thresholds. Consumes the one-cycle
// key strobe and scan code from the PS/2 break-code filter. Decodes

---
 rtl/param_entry_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_param_entry_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_entry_ctrl.sv
// Keyboard entry sequencer for alarm thresholds: decodes select/digit/enter/cancel
// key strobes and holds the committed thresholds for the alarm comparators.
//
// state | meaning
// IDLE  | no entry in progress, timer held at 0
// SEL_H | H seen, waiting for A (smoke alert) or P (smoke danger)
// SEL_G | G seen, waiting for A (gas alert)
// DIG   | collecting decimal digits for the selected target
module param_entry_ctrl #(
   parameter int DW          = 8,
   parameter int MAX_DIGITS  = 2,
   parameter int TIMEOUT_CYC = 100000000,
   parameter int TEMP_DEF    = 30,
   parameter int SMK_A_DEF   = 40,
   parameter int SMK_P_DEF   = 70,
   parameter int GAS_A_DEF   = 50
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          key_tick,
   input  logic [7:0]    key_code,
   output logic [DW-1:0] temp_thr,
   output logic [DW-1:0] smoke_alert_thr,
   output logic [DW-1:0] smoke_danger_thr,
   output logic [DW-1:0] gas_alert_thr,
   output logic          cfg_update,
   output logic          entry_busy,
   output logic          entry_err
);

   localparam int AW = $clog2(10**MAX_DIGITS);
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, SEL_H, SEL_G, DIG} state_t;
   typedef enum logic [1:0] {TGT_TEMP, TGT_SMK_A, TGT_SMK_P, TGT_GAS_A} tgt_t;

   state_t        state, state_n;
   tgt_t          tgt, tgt_n;
   logic [AW-1:0] acc, acc_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [TW-1:0] timer, timer_n;
   logic [DW-1:0] temp_n, smk_a_n, smk_p_n, gas_a_n;
   logic          upd_n, err_n, expired;

   logic          is_dig, is_h, is_g, is_a, is_p, is_ent, is_r;
   logic [3:0]    dval;

   always_comb begin
      is_dig = 1'b1;
      dval   = 4'd0;
      case (key_code)
         8'h16:   dval = 4'd1;
         8'h1E:   dval = 4'd2;
         8'h26:   dval = 4'd3;
         8'h25:   dval = 4'd4;
         8'h2E:   dval = 4'd5;
         8'h36:   dval = 4'd6;
         8'h3D:   dval = 4'd7;
         8'h3E:   dval = 4'd8;
         8'h46:   dval = 4'd9;
         8'h45:   dval = 4'd0;
         default: is_dig = 1'b0;
      endcase
      is_h   = (key_code == 8'h33);
      is_a   = (key_code == 8'h1C);
      is_p   = (key_code == 8'h4D);
      is_g   = (key_code == 8'h34);
      is_ent = (key_code == 8'h5A);
      is_r   = (key_code == 8'h2D);
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         tgt              <= TGT_TEMP;
         acc              <= '0;
         cnt              <= '0;
         timer            <= '0;
         temp_thr         <= DW'(TEMP_DEF);
         smoke_alert_thr  <= DW'(SMK_A_DEF);
         smoke_danger_thr <= DW'(SMK_P_DEF);
         gas_alert_thr    <= DW'(GAS_A_DEF);
         cfg_update       <= 1'b0;
         entry_err        <= 1'b0;
      end else begin
         state            <= state_n;
         tgt              <= tgt_n;
         acc              <= acc_n;
         cnt              <= cnt_n;
         timer            <= timer_n;
         temp_thr         <= temp_n;
         smoke_alert_thr  <= smk_a_n;
         smoke_danger_thr <= smk_p_n;
         gas_alert_thr    <= gas_a_n;
         cfg_update       <= upd_n;
         entry_err        <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      tgt_n   = tgt;
      acc_n   = acc;
      cnt_n   = cnt;
      temp_n  = temp_thr;
      smk_a_n = smoke_alert_thr;
      smk_p_n = smoke_danger_thr;
      gas_a_n = gas_alert_thr;
      upd_n   = 1'b0;
      err_n   = 1'b0;
      // a key arriving in the expiry cycle suppresses the timeout
      expired = (state != IDLE) && !key_tick && (timer == TW'(TIMEOUT_CYC - 1));

      if (expired) begin
         state_n = IDLE;
         err_n   = 1'b1;
      end else if (key_tick) begin
         case (state)
            IDLE: begin
               if (is_dig) begin
                  state_n = DIG;
                  tgt_n   = TGT_TEMP;
                  acc_n   = AW'(dval);
                  cnt_n   = CW'(1);
               end else if (is_h) begin
                  state_n = SEL_H;
               end else if (is_g) begin
                  state_n = SEL_G;
               end
            end
            SEL_H: begin
               if (is_a || is_p) begin
                  state_n = DIG;
                  if (is_a) tgt_n = TGT_SMK_A;
                  else      tgt_n = TGT_SMK_P;
                  acc_n   = '0;
                  cnt_n   = '0;
               end else if (is_r) begin
                  state_n = IDLE;
               end else if (is_dig || is_g || is_h || is_ent) begin
                  state_n = IDLE;
                  err_n   = 1'b1;
               end
            end
            SEL_G: begin
               if (is_a) begin
                  state_n = DIG;
                  tgt_n   = TGT_GAS_A;
                  acc_n   = '0;
                  cnt_n   = '0;
               end else if (is_r) begin
                  state_n = IDLE;
               end else if (is_dig || is_h || is_g || is_p || is_ent) begin
                  state_n = IDLE;
                  err_n   = 1'b1;
               end
            end
            DIG: begin
               if (is_dig) begin
                  if (cnt < CW'(MAX_DIGITS)) begin
                     acc_n = acc * AW'(10) + AW'(dval);
                     cnt_n = cnt + CW'(1);
                  end else begin
                     state_n = IDLE;
                     err_n   = 1'b1;
                  end
               end else if (is_ent) begin
                  state_n = IDLE;
                  if (cnt != '0) begin
                     upd_n = 1'b1;
                     case (tgt)
                        TGT_TEMP:  temp_n  = DW'(acc);
                        TGT_SMK_A: smk_a_n = DW'(acc);
                        TGT_SMK_P: smk_p_n = DW'(acc);
                        default:   gas_a_n = DW'(acc);
                     endcase
                  end else begin
                     err_n = 1'b1;
                  end
               end else if (is_r) begin
                  state_n = IDLE;
               end else if (is_h || is_g || is_a || is_p) begin
                  state_n = IDLE;
                  err_n   = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end

      if (state_n == IDLE || key_tick) timer_n = '0;
      else                             timer_n = timer + TW'(1);
   end

   assign entry_busy = (state != IDLE);

endmodule

// File: tb/tb_param_entry_ctrl.sv
// Randomized bench for param_entry_ctrl: a key-sequence reference model feeds
// a scoreboard that a separate monitor drains as the DUT pulses.
module tb_param_entry_ctrl;
   localparam int TO   = 20;
   localparam int MAXD = 2;

   localparam int K_DIG = 0, K_H = 1, K_G = 2, K_A = 3, K_P = 4, K_E = 5, K_R = 6, K_OTH = 7;

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic       key_tick = 1'b0;
   logic [7:0] key_code = 8'h00;
   logic [7:0] temp_thr, smoke_alert_thr, smoke_danger_thr, gas_alert_thr;
   logic       cfg_update, entry_busy, entry_err;

   param_entry_ctrl #(.DW(8), .MAX_DIGITS(MAXD), .TIMEOUT_CYC(TO)) dut (
      .CLK(CLK), .reset(reset), .key_tick(key_tick), .key_code(key_code),
      .temp_thr(temp_thr), .smoke_alert_thr(smoke_alert_thr),
      .smoke_danger_thr(smoke_danger_thr), .gas_alert_thr(gas_alert_thr),
      .cfg_update(cfg_update), .entry_busy(entry_busy), .entry_err(entry_err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int kind;   // 0 none, 1 commit, 2 error
      int busy;
      int t0, t1, t2, t3;
   } exp_t;

   exp_t st_q[$];
   exp_t ev_q[$];
   int   tests = 0;
   int   failed = 0;

   int   dig_codes[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};

   // reference model: an entry is a prefix letter plus a list of typed digits
   int     m_thr[4];
   bit     m_in;
   int     m_pre;   // 0 target chosen, 1 waiting after H, 2 waiting after G
   int     m_tgt;
   int     m_digs[$];
   longint cyc, last_key;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int kclass(input logic [7:0] c, output int d);
      d = 0;
      for (int i = 0; i < 10; i++)
         if (c == 8'(dig_codes[i])) begin
            d = i;
            return K_DIG;
         end
      case (c)
         8'h33:   return K_H;
         8'h34:   return K_G;
         8'h1C:   return K_A;
         8'h4D:   return K_P;
         8'h5A:   return K_E;
         8'h2D:   return K_R;
         default: return K_OTH;
      endcase
   endfunction

   task automatic model_reset();
      m_thr = '{30, 40, 70, 50};
      m_in = 0;
      m_pre = 0;
      m_tgt = 0;
      m_digs.delete();
      last_key = cyc;
   endtask

   task automatic model_edge(input bit tick, input logic [7:0] code, output int ev);
      int k, d, v;
      ev = 0;
      if (tick) begin
         last_key = cyc;
         k = kclass(code, d);
         if (k == K_OTH) begin
         end else if (!m_in) begin
            if (k == K_DIG) begin
               m_in = 1; m_pre = 0; m_tgt = 0; m_digs = '{d};
            end else if (k == K_H || k == K_G) begin
               m_in = 1; m_pre = (k == K_H) ? 1 : 2;
            end
         end else if (k == K_R) begin
            m_in = 0;
         end else if (m_pre != 0) begin
            if (m_pre == 1 && (k == K_A || k == K_P)) begin
               m_pre = 0; m_tgt = (k == K_A) ? 1 : 2; m_digs.delete();
            end else if (m_pre == 2 && k == K_A) begin
               m_pre = 0; m_tgt = 3; m_digs.delete();
            end else begin
               m_in = 0; ev = 2;
            end
         end else if (k == K_DIG) begin
            if (m_digs.size() < MAXD) m_digs.push_back(d);
            else begin m_in = 0; ev = 2; end
         end else if (k == K_E && m_digs.size() > 0) begin
            v = 0;
            foreach (m_digs[i]) v = v * 10 + m_digs[i];
            m_thr[m_tgt] = v;
            m_in = 0; ev = 1;
         end else begin
            m_in = 0; ev = 2;
         end
      end else if (m_in && (cyc - last_key) == TO) begin
         m_in = 0; ev = 2;
      end
      cyc++;
   endtask

   task automatic push_exp(input int ev);
      exp_t e;
      e.kind = ev; e.busy = m_in ? 1 : 0;
      e.t0 = m_thr[0]; e.t1 = m_thr[1]; e.t2 = m_thr[2]; e.t3 = m_thr[3];
      st_q.push_back(e);
      if (ev != 0) ev_q.push_back(e);
   endtask

   task automatic drive(input bit tick, input logic [7:0] code);
      int ev;
      @(negedge CLK);
      reset = 1'b1;
      key_tick = tick;
      key_code = tick ? code : 8'($urandom);
      model_edge(tick, code, ev);
      push_exp(ev);
   endtask

   task automatic key(input logic [7:0] code);
      drive(1'b1, code);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      reset = 1'b0;
      key_tick = 1'b0;
      cyc++;
      model_reset();
      push_exp(0);
   endtask

   // monitor: every cycle compare registered state, and pop the event scoreboard on pulses
   initial begin
      exp_t e;
      int   act;
      forever begin
         @(posedge CLK);
         #1;
         act = cfg_update ? 1 : (entry_err ? 2 : 0);
         if (st_q.size() > 0) begin
            e = st_q.pop_front();
            chk("pulse_kind", act, e.kind);
            chk("entry_busy", int'(entry_busy), e.busy);
            chk("temp_thr", int'(temp_thr), e.t0);
            chk("smoke_alert_thr", int'(smoke_alert_thr), e.t1);
            chk("smoke_danger_thr", int'(smoke_danger_thr), e.t2);
            chk("gas_alert_thr", int'(gas_alert_thr), e.t3);
         end
         if (cfg_update && entry_err) chk("upd_err_exclusive", 1, 0);
         if (act != 0) begin
            if (ev_q.size() == 0) chk("unexpected_pulse", act, 0);
            else begin
               e = ev_q.pop_front();
               chk("scoreboard_event", act, e.kind);
            end
         end
      end
   end

   initial begin
      int r;
      cyc = 0;
      model_reset();
      do_reset();
      do_reset();

      // T1
      key(8'h2E); key(8'h45); key(8'h5A); idle(2);
      // T2
      key(8'h33); key(8'h4D); key(8'h46); key(8'h36); key(8'h5A); idle(1);
      key(8'h34); key(8'h1C); key(8'h1E); key(8'h5A); idle(1);
      // T3
      key(8'h33); key(8'h1C); key(8'h16); key(8'h1E); key(8'h26); idle(2);
      // T4
      key(8'h34); key(8'h4D); idle(1);
      key(8'h16); key(8'h2D); idle(2);
      // T5: timeout, then a key landing exactly in the expiry cycle
      key(8'h33); idle(TO + 2);
      key(8'h33); idle(TO - 1); key(8'h1C); idle(3); key(8'h2D); idle(1);
      // T6
      key(8'h16); key(8'h1E); do_reset(); key(8'h5A); idle(2);
      // ENTER without digits, unknown codes, zero-valued commits
      key(8'h33); key(8'h1C); key(8'h5A); idle(1);
      key(8'hF0); key(8'h45); key(8'h00); key(8'h5A); idle(1);

      for (int n = 0; n < 500; n++) begin
         r = $urandom_range(0, 11);
         case (r)
            0, 1, 2, 3: key(8'(dig_codes[$urandom_range(0, 9)]));
            4:          key(8'h33);
            5:          key(8'h34);
            6:          key($urandom_range(0, 1) ? 8'h1C : 8'h4D);
            7, 8:       key(8'h5A);
            9:          key(8'h2D);
            10:         key($urandom_range(0, 1) ? 8'h1B : 8'hF0);
            default:    if ($urandom_range(0, 7) == 0) do_reset(); else key(8'h5A);
         endcase
         if ($urandom_range(0, 14) == 0) idle($urandom_range(TO - 2, TO + 2));
         else idle($urandom_range(0, 2));
      end
      idle(TO + 3);
      repeat (2) @(posedge CLK);
      #2;
      chk("scoreboard_drained", ev_q.size(), 0);
      chk("state_queue_drained", st_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
